// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the redirect-source encoding used by the fetch PC unit.
package cpu_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        RD_NONE,
        RD_BR,
        RD_J,
        RD_JR,
        RD_PEND
    } redirect_src_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-stage redirect/stall request bundle and the PC unit's responses.
interface pc_sequencer_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned JIDX_W = 26
);
    logic              stall;
    logic              br_taken;
    logic [WIDTH-1:0]  br_base;
    logic [IMM_W-1:0]  br_imm;
    logic              jump;
    logic [JIDX_W-1:0] jidx;
    logic              jr;
    logic [WIDTH-1:0]  jr_target;
    logic [WIDTH-1:0]  pc;
    logic [WIDTH-1:0]  pc4;
    logic              flush;
    logic              fault;
    logic [WIDTH-1:0]  fault_addr;
    logic              pend;

    modport master (
        output stall, br_taken, br_base, br_imm, jump, jidx, jr, jr_target,
        input  pc, pc4, flush, fault, fault_addr, pend
    );

    modport slave (
        input  stall, br_taken, br_base, br_imm, jump, jidx, jr, jr_target,
        output pc, pc4, flush, fault, fault_addr, pend
    );
endinterface

// File: rtl/pc_sequencer_target_calc.sv
// Combinational branch and jump target generation; jump form selected by JUMP_MODE.
module target_calc #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned IMM_W     = 16,
    parameter int unsigned JIDX_W    = 26,
    parameter int unsigned JUMP_MODE = 0
) (
    input  logic [WIDTH-1:0]  pc4_i,
    input  logic [WIDTH-1:0]  br_base_i,
    input  logic [IMM_W-1:0]  br_imm_i,
    input  logic [JIDX_W-1:0] jidx_i,
    output logic [WIDTH-1:0]  br_target_o,
    output logic [WIDTH-1:0]  j_target_o
);

    logic [WIDTH-1:0] br_off;

    assign br_off      = {{(WIDTH-IMM_W){br_imm_i[IMM_W-1]}}, br_imm_i};
    assign br_target_o = br_base_i + (br_off << 2);

    generate
        if (JUMP_MODE == 0) begin : g_region
            // Low bits of pc4 are replaced by the index, so only the region bits are consumed.
            if (WIDTH > JIDX_W + 2) begin : g_hi
                logic unused_pc4_lo;
                assign unused_pc4_lo = ^pc4_i[JIDX_W+1:0];
                assign j_target_o    = {pc4_i[WIDTH-1:JIDX_W+2], jidx_i, 2'b00};
            end else begin : g_full
                logic unused_pc4;
                assign unused_pc4 = ^pc4_i;
                assign j_target_o = {jidx_i, 2'b00};
            end
        end else begin : g_rel
            logic [WIDTH-1:0] j_off;
            assign j_off      = {{(WIDTH-JIDX_W){jidx_i[JIDX_W-1]}}, jidx_i};
            assign j_target_o = pc4_i + (j_off << 2);
        end
    endgenerate

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with redirect arbitration, stall hold and a one-entry pending-redirect buffer.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      IMM_W     = 16,
    parameter int unsigned      JIDX_W    = 26,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned      JUMP_MODE = 0
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    localparam logic [WIDTH-1:0] PC_INC = WIDTH'(INSTR_BYTES);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] ptgt_q, ptgt_d;
    logic             flush_q, flush_d;
    logic             fault_q, fault_d;
    logic [WIDTH-1:0] faddr_q, faddr_d;

    logic [WIDTH-1:0] pc4_c;
    logic [WIDTH-1:0] br_target_c;
    logic [WIDTH-1:0] j_target_c;
    logic             jr_misaligned_c;
    redirect_src_t    new_src_c;
    logic [WIDTH-1:0] new_tgt_c;
    redirect_src_t    eff_src_c;
    logic [WIDTH-1:0] eff_tgt_c;

    assign pc4_c           = pc_q + PC_INC;
    assign jr_misaligned_c = bus.jr && (bus.jr_target[1:0] != 2'b00);

    target_calc #(
        .WIDTH     (WIDTH),
        .IMM_W     (IMM_W),
        .JIDX_W    (JIDX_W),
        .JUMP_MODE (JUMP_MODE)
    ) u_target_calc (
        .pc4_i       (pc4_c),
        .br_base_i   (bus.br_base),
        .br_imm_i    (bus.br_imm),
        .jidx_i      (bus.jidx),
        .br_target_o (br_target_c),
        .j_target_o  (j_target_c)
    );

    // jr > jump > br; a misaligned jr still claims the slot and suppresses the lower requests.
    always_comb begin
        new_src_c = RD_NONE;
        new_tgt_c = '0;
        if (bus.jr) begin
            if (!jr_misaligned_c) begin
                new_src_c = RD_JR;
                new_tgt_c = bus.jr_target;
            end
        end else if (bus.jump) begin
            new_src_c = RD_J;
            new_tgt_c = j_target_c;
        end else if (bus.br_taken) begin
            new_src_c = RD_BR;
            new_tgt_c = br_target_c;
        end
    end

    // The buffered redirect is older than anything arriving now, so it always wins.
    always_comb begin
        eff_src_c = new_src_c;
        eff_tgt_c = new_tgt_c;
        if (pend_q) begin
            eff_src_c = RD_PEND;
            eff_tgt_c = ptgt_q;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        pend_d  = pend_q;
        ptgt_d  = ptgt_q;
        flush_d = 1'b0;
        fault_d = jr_misaligned_c;
        faddr_d = jr_misaligned_c ? bus.jr_target : faddr_q;
        if (!bus.stall) begin
            if (eff_src_c != RD_NONE) begin
                pc_d    = eff_tgt_c;
                pend_d  = 1'b0;
                flush_d = 1'b1;
            end else begin
                pc_d = pc4_c;
            end
        end else if (!pend_q && (new_src_c != RD_NONE)) begin
            pend_d = 1'b1;
            ptgt_d = new_tgt_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            pend_q  <= 1'b0;
            ptgt_q  <= '0;
            flush_q <= 1'b0;
            fault_q <= 1'b0;
            faddr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            ptgt_q  <= ptgt_d;
            flush_q <= flush_d;
            fault_q <= fault_d;
            faddr_q <= faddr_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc4        = pc4_c;
    assign bus.flush      = flush_q;
    assign bus.fault      = fault_q;
    assign bus.fault_addr = faddr_q;
    assign bus.pend       = pend_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench: region-jump and PC-relative-jump instances driven in lockstep against a reference model.
module tb_pc_sequencer;

    typedef struct packed {
        logic [31:0] pc;
        logic        flush;
        logic        fault;
        logic [31:0] faddr;
        logic        pend;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_sequencer_if #(.WIDTH(32), .IMM_W(16), .JIDX_W(26)) if0 ();
    pc_sequencer_if #(.WIDTH(32), .IMM_W(16), .JIDX_W(26)) if1 ();

    pc_sequencer #(.WIDTH(32), .IMM_W(16), .JIDX_W(26), .RESET_PC(32'h0), .JUMP_MODE(0))
        u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    pc_sequencer #(.WIDTH(32), .IMM_W(16), .JIDX_W(26), .RESET_PC(32'h0), .JUMP_MODE(1))
        u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Reference state: index 0 = region jumps, index 1 = PC-relative jumps.
    logic [31:0] m_pc[2];
    logic [31:0] m_ptgt[2];
    logic [31:0] m_faddr[2];
    bit          m_pend[2];
    bit          m_flush[2];
    bit          m_fault[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] br_target(input logic [31:0] base, input logic [15:0] imm);
        longint off;
        off = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
        return 32'(longint'(base) + off * 4);
    endfunction

    function automatic logic [31:0] j_target(input int m, input logic [31:0] pc4, input logic [25:0] ji);
        longint off;
        if (m == 0) return (pc4 & 32'hF000_0000) | (32'(ji) * 4);
        off = (ji >= 26'h200_0000) ? longint'(ji) - 67108864 : longint'(ji);
        return 32'(longint'(pc4) + off * 4);
    endfunction

    task automatic model_step(input int m, input bit rst, input bit st, input bit bt,
                              input logic [31:0] bb, input logic [15:0] bi, input bit j,
                              input logic [25:0] ji, input bit r, input logic [31:0] rt);
        logic [31:0] pc4, tgt;
        bit          have;
        if (rst) begin
            m_pc[m] = 32'h0; m_pend[m] = 0; m_ptgt[m] = 32'h0;
            m_flush[m] = 0; m_fault[m] = 0; m_faddr[m] = 32'h0;
            return;
        end
        pc4  = m_pc[m] + 32'd4;
        have = 0;
        tgt  = 32'h0;
        if (r) begin
            if (rt % 4 == 0) begin have = 1; tgt = rt; end
        end else if (j) begin
            have = 1; tgt = j_target(m, pc4, ji);
        end else if (bt) begin
            have = 1; tgt = br_target(bb, bi);
        end
        m_fault[m] = r && (rt % 4 != 0);
        if (m_fault[m]) m_faddr[m] = rt;
        if (st) begin
            m_flush[m] = 0;
            if (!m_pend[m] && have) begin m_pend[m] = 1; m_ptgt[m] = tgt; end
        end else if (m_pend[m]) begin
            m_pc[m] = m_ptgt[m]; m_pend[m] = 0; m_flush[m] = 1;
        end else if (have) begin
            m_pc[m] = tgt; m_flush[m] = 1;
        end else begin
            m_pc[m] = pc4; m_flush[m] = 0;
        end
    endtask

    task automatic drive(input bit rst, input bit st, input bit bt, input logic [31:0] bb,
                         input logic [15:0] bi, input bit j, input logic [25:0] ji,
                         input bit r, input logic [31:0] rt);
        exp_t e;
        @(negedge clk);
        reset = rst;
        if0.stall = st; if0.br_taken = bt; if0.br_base = bb; if0.br_imm = bi;
        if0.jump = j; if0.jidx = ji; if0.jr = r; if0.jr_target = rt;
        if1.stall = st; if1.br_taken = bt; if1.br_base = bb; if1.br_imm = bi;
        if1.jump = j; if1.jidx = ji; if1.jr = r; if1.jr_target = rt;
        for (int m = 0; m < 2; m++) begin
            model_step(m, rst, st, bt, bb, bi, j, ji, r, rt);
            e = '{pc: m_pc[m], flush: m_flush[m], fault: m_fault[m], faddr: m_faddr[m], pend: m_pend[m]};
            if (m == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic idle(input bit st);
        drive(0, st, 0, 32'h0, 16'h0, 0, 26'h0, 0, 32'h0);
    endtask

    task automatic jr_to(input logic [31:0] t);
        drive(0, 0, 0, 32'h0, 16'h0, 0, 26'h0, 1, t);
    endtask

    // Hand-derived absolute expectations, checked just after the edge that applies the last drive.
    task automatic expect_st(input string name, input logic [31:0] pc0, input logic [31:0] pc1,
                             input bit fl, input bit pd);
        @(posedge clk);
        #3;
        check({name, ".pc0"}, if0.pc, pc0);
        check({name, ".pc1"}, if1.pc, pc1);
        check({name, ".flush"}, 32'(if0.flush), 32'(fl));
        check({name, ".pend"}, 32'(if0.pend), 32'(pd));
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [31:0] pc, input logic [31:0] pc4,
                       input logic fl, input logic ft, input logic [31:0] fa, input logic pd);
        check({tag, ".pc"}, pc, e.pc);
        check({tag, ".pc4"}, pc4, e.pc + 32'd4);
        check({tag, ".flush"}, 32'(fl), 32'(e.flush));
        check({tag, ".fault"}, 32'(ft), 32'(e.fault));
        check({tag, ".fault_addr"}, fa, e.faddr);
        check({tag, ".pend"}, 32'(pd), 32'(e.pend));
    endtask

    // Monitor: every clock the DUTs present state; pop the matching expectation and compare.
    always @(posedge clk) begin
        #2;
        if (q0.size() > 0) cmp("dut0", q0.pop_front(), if0.pc, if0.pc4, if0.flush, if0.fault, if0.fault_addr, if0.pend);
        if (q1.size() > 0) cmp("dut1", q1.pop_front(), if1.pc, if1.pc4, if1.flush, if1.fault, if1.fault_addr, if1.pend);
    end

    initial begin
        bit          st, bt, j, r, rst;
        logic [31:0] bb, rt;
        logic [15:0] bi;
        logic [25:0] ji;

        drive(1, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 32'h0);
        drive(1, 0, 0, 32'h0, 16'h0, 0, 26'h0, 0, 32'h0);
        expect_st("reset", 32'h0, 32'h0, 0, 0);
        idle(0); expect_st("run1", 32'h4, 32'h4, 0, 0);
        idle(0); expect_st("run2", 32'h8, 32'h8, 0, 0);
        idle(0); expect_st("run3", 32'hC, 32'hC, 0, 0);

        jr_to(32'h100); expect_st("jr100", 32'h100, 32'h100, 1, 0);
        drive(0, 0, 1, 32'h104, 16'hFFFE, 0, 26'h0, 0, 32'h0);
        expect_st("br_back", 32'hFC, 32'hFC, 1, 0);
        idle(0); expect_st("br_after", 32'h100, 32'h100, 0, 0);

        jr_to(32'h0040_0010); expect_st("jr_far", 32'h0040_0010, 32'h0040_0010, 1, 0);
        drive(0, 1, 0, 32'h0, 16'h0, 1, 26'h40, 0, 32'h0);
        expect_st("stall_j", 32'h0040_0010, 32'h0040_0010, 0, 1);
        drive(0, 1, 1, 32'h0, 16'h5, 0, 26'h0, 0, 32'h0);
        expect_st("stall_br", 32'h0040_0010, 32'h0040_0010, 0, 1);
        idle(1); expect_st("stall3", 32'h0040_0010, 32'h0040_0010, 0, 1);
        idle(0); expect_st("release", 32'h100, 32'h0040_0114, 1, 0);

        jr_to(32'h1002); expect_st("jr_mis", 32'h104, 32'h0040_0118, 0, 0);
        check("jr_mis.fault", 32'(if0.fault), 32'h1);
        check("jr_mis.fault_addr", if0.fault_addr, 32'h1002);
        idle(0); expect_st("post_fault", 32'h108, 32'h0040_011C, 0, 0);
        check("post_fault.fault", 32'(if0.fault), 32'h0);
        check("post_fault.fault_addr", if1.fault_addr, 32'h1002);

        drive(0, 0, 1, 32'h500, 16'h3, 1, 26'h55, 1, 32'h2000);
        expect_st("prio", 32'h2000, 32'h2000, 1, 0);
        drive(0, 0, 0, 32'h0, 16'h0, 1, 26'h3FF_FFFF, 0, 32'h0);
        expect_st("jneg", 32'h0FFF_FFFC, 32'h2000, 1, 0);

        drive(0, 1, 0, 32'h0, 16'h0, 1, 26'h10, 0, 32'h0);
        expect_st("pend_set", 32'h0FFF_FFFC, 32'h2000, 0, 1);
        drive(1, 1, 0, 32'h0, 16'h0, 0, 26'h0, 0, 32'h0);
        expect_st("rst_pend", 32'h0, 32'h0, 0, 0);
        idle(0); expect_st("rst_pend1", 32'h4, 32'h4, 0, 0);
        idle(0); expect_st("rst_pend2", 32'h8, 32'h8, 0, 0);

        jr_to(32'hFFFF_FFFC); expect_st("wrap0", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0);
        idle(0); expect_st("wrap1", 32'h0, 32'h0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            st  = ($urandom_range(0, 9) < 3);
            r   = ($urandom_range(0, 99) < 15);
            j   = ($urandom_range(0, 99) < 20);
            bt  = ($urandom_range(0, 99) < 25);
            bb  = $urandom & 32'hFFFF_FFFC;
            bi  = 16'($urandom);
            ji  = 26'($urandom);
            rt  = $urandom;
            if ($urandom_range(0, 9) < 8) rt = rt & 32'hFFFF_FFFC;
            if ($urandom_range(0, 19) == 0) rt = 32'hFFFF_FFF8;
            drive(rst, st, bt, bb, bi, j, ji, r, rt);
        end

        idle(0);
        repeat (3) @(posedge clk);
        #4;
        check("drain", 32'(q0.size() + q1.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit for the CPU fetch stage. It supersedes the discrete sign-extend, shift-left-2, adder and 2:1 mux glue that computes next-PC.
- Holds the architectural PC register and computes PC+4, branch and jump targets internally. It arbitrates redirects and supports stalls.
- A one-entry pending-redirect buffer ensures a redirect raised during a stall is not lost.
- Outputs feed instruction memory and the IF/ID pipeline register.

Parameters:
- WIDTH, 32, address/PC width in bits (>= 28 when JUMP_MODE=0).
- IMM_W, 16, branch offset field width (word offset).
- JIDX_W, 26, jump index field width.
- RESET_PC, 0, PC value loaded on reset (must be 4-byte aligned).
- JUMP_MODE, 0. 0 = region jump {pc4[WIDTH-1:JIDX_W+2], jidx, 2'b00}. 1 = PC-relative jump pc4 + (sext(jidx) << 2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; fetch does not advance.
- br_taken  in  1  branch resolved taken this cycle.
- br_base  in  WIDTH  PC+4 of the branching instruction.
- br_imm  in  IMM_W  signed word offset.
- jump  in  1  direct jump request.
- jidx  in  JIDX_W  jump index/offset field.
- jr  in  1  register-indirect jump request.
- jr_target  in  WIDTH  register jump target.
- pc  out  WIDTH  current fetch PC (registered).
- pc4  out  WIDTH  pc + 4 (combinational from pc).
- flush  out  1  registered pulse; the IF/ID instruction fetched in the previous cycle must be squashed.
- fault  out  1  registered one-cycle pulse on a misaligned jr target.
- fault_addr  out  WIDTH  offending jr target; holds until the next fault.
- pend  out  1  pending-redirect buffer occupied (debug/verification).

Behaviour:
- Reset (sync, priority over all): pc=RESET_PC, pend=0, flush=0, fault=0, fault_addr=0.
- Arithmetic: all sums modulo 2^WIDTH, no overflow detection.
  - Branch target = br_base + (sext(br_imm) << 2).
  - jr_target is used as given.
- Request selection in one cycle, priority jr > jump > br_taken. Lower-priority requests in the same cycle are dropped.
- jr with jr_target[1:0] != 0:
  - The request is discarded, with no redirect and no pend.
  - Next cycle fault=1 and fault_addr=jr_target.
  - pc follows the normal stall/increment rule.
- Effective redirect this cycle: the pending entry if pend=1, else the new valid request. The older pending entry always wins over a simultaneous new request, and that new request is dropped.
- Next-state when stall=0:
  - With an effective redirect: pc <= target, pend <= 0, flush <= 1.
  - Otherwise: pc <= pc+4, flush <= 0.
- Next-state when stall=1:
  - pc holds and flush <= 0.
  - If pend=0 and a valid new request exists, capture its target into the buffer: pend <= 1.
  - If pend=1, new requests are ignored (younger instructions will be squashed).
- Latency: a redirect requested in cycle N with stall=0 gives pc=target and flush=1 in cycle N+1.
- Wrap-around: pc=2^WIDTH-4 with no redirect gives next pc=0.
- fault never blocks a simultaneous valid redirect from the pending buffer.

Decomposition:
- Shared package cpu_pkg holds:
  - constants INSTR_BYTES=4 and RESET_PC default;
  - enum redirect_src_t {RD_NONE, RD_BR, RD_J, RD_JR, RD_PEND}.
- One natural sub-module, target_calc: combinational computation of branch and jump targets from pc4/br_base/br_imm/jidx per JUMP_MODE.
- The PC register, pending buffer and arbitration stay in pc_sequencer.

Test Plan:
- Reset, then 3 cycles free-run, stall=0 -> pc = 0x0, 0x4, 0x8, 0xC; flush=0 throughout.
- At pc=0x100: br_taken=1, br_base=0x104, br_imm=0xFFFE -> next pc=0x0FC, flush=1 for exactly one cycle.
- stall=1 with jump=1, jidx=0x40, pc=0x00400010 (JUMP_MODE=0). Hold 3 cycles, with a br_taken in cycle 2.
  - During the stall: pend=1 and pc unchanged.
  - On release: pc=0x00000100, flush=1, and the branch is ignored.
- jr=1 with jr_target=0x1002 -> no redirect, pc advances by 4, fault=1 one cycle, fault_addr=0x1002.
- Simultaneous jr (0x2000), jump and br_taken, stall=0 -> pc=0x2000; with JUMP_MODE=1, jidx=-1 alone gives pc = pc4 - 4.
- reset asserted mid-stall with pend=1 -> next cycle pc=RESET_PC, pend=0, and no later flush from the stale entry.
- Wrap: force pc=0xFFFFFFFC via a jr redirect -> pc goes 0xFFFFFFFC then 0x00000000.
